// File: rtl/mod_inverse_if.sv
// Request/result bundle for the modular inverter: start/a/q in, busy/done/err/out back.
// Latency: n/a (wiring only).
// Backpressure: none; the requester watches busy/done and holds off new starts itself.
interface mod_inverse_if #(
  parameter int WIDTH = 28
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] out;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, q,
    input  busy, done, err, out
  );

  // Inverter side: consumes operands, reports status and result
  modport slave (
    input  start, a, q,
    output busy, done, err, out
  );
endinterface

// File: rtl/mod_inverse.sv
// Sequential modular inverter, out = a^-1 mod q, binary extended Euclid, one step per clock.
// Latency: start to done <= 4*WIDTH+2 cycles; exactly 4*WIDTH+2 with MODINV_CONST_TIME_EN defined.
// Backpressure: one op in flight; start ignored while busy and in the done cycle, no queueing.
module mod_inverse #(
  parameter int WIDTH = 28
) (
  input  logic         clk,
  input  logic         rst,
  mod_inverse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;

  // Working set: invariants x1*a == u and x2*a == v (mod q)
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] q_reg;
  logic             err_pend;

  // Registered outputs
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic [WIDTH-1:0] out_reg;

  // Control strobes from the FSM
  logic             accept;
  logic             bad_in;
  logic             hit_one;
  logic             hit_zero;
  logic             do_load;
  logic             do_step;
  logic             set_err;

  // One algorithm step computed from the current working set
  logic [WIDTH-1:0] u_step;
  logic [WIDTH-1:0] v_step;
  logic [WIDTH-1:0] x1_step;
  logic [WIDTH-1:0] x2_step;

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.err  = err_reg;
  assign bus.out  = out_reg;

  // Done cycle already has busy low, so done_reg is what keeps a start there from being taken
  assign accept   = (state == IDLE) && bus.start && !done_reg;
  assign bad_in   = (bus.a == '0) || (bus.a >= bus.q);
  assign hit_one  = (u == ONE) || (v == ONE);
  assign hit_zero = (u == '0) || (v == '0);

  // x/2 mod m for odd m: add m to an odd x first, the sum needs one extra bit
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // (x - y) mod m for x, y in [0, m); the wrap of x-y is undone by adding m
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    return (x >= y) ? (x - y) : (x - y + m);
  endfunction

  // Next working set for one iteration: halve an even side, else subtract the smaller odd side
  always_comb begin
    u_step  = u;
    v_step  = v;
    x1_step = x1;
    x2_step = x2;
    if (!u[0]) begin
      u_step  = u >> 1;
      x1_step = half_mod(x1, q_reg);
    end else if (!v[0]) begin
      v_step  = v >> 1;
      x2_step = half_mod(x2, q_reg);
    end else if (u >= v) begin
      u_step  = u - v;
      x1_step = sub_mod(x1, x2, q_reg);
    end else begin
      v_step  = v - u;
      x2_step = sub_mod(x2, x1, q_reg);
    end
  end

`ifdef MODINV_CONST_TIME_EN
  // RUN lasts 4*WIDTH+1 cycles: accept edge + RUN + FIN puts done exactly 4*WIDTH+2 after start
  localparam int TOTAL_LAT = 4 * WIDTH + 2;
  localparam int CNT_W     = $clog2(TOTAL_LAT);
  localparam int CNT_LAST  = TOTAL_LAT - 2;

  logic [CNT_W-1:0] cnt;
  logic             halt;
  logic             set_halt;

  // Pad counter and freeze flag; invalid operands are frozen from the start
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      halt <= 1'b0;
    end else begin
      if (do_load) begin
        cnt  <= '0;
        halt <= bad_in;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        if (set_halt) begin
          halt <= 1'b1;
        end
      end
    end
  end

  // Next state and strobes; the algorithm freezes once finished and RUN waits out the counter
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    set_err   = 1'b0;
    set_halt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          do_load   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!halt) begin
          if (hit_one) begin
            set_halt = 1'b1;
          end else if (hit_zero) begin
            set_halt = 1'b1;
            set_err  = 1'b1;
          end else begin
            do_step = 1'b1;
          end
        end
        if (cnt == CNT_W'(CNT_LAST)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
`else
  // Next state and strobes; leave RUN as soon as one side reaches 1 (done) or 0 (gcd != 1)
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          do_load   = 1'b1;
          state_nxt = bad_in ? FIN : RUN;
        end
      end
      RUN: begin
        if (hit_one) begin
          state_nxt = FIN;
        end else if (hit_zero) begin
          set_err   = 1'b1;
          state_nxt = FIN;
        end else begin
          do_step = 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Working set load/step, and result capture with a one-cycle done pulse in FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      q_reg    <= '0;
      err_pend <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      out_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      if (do_load) begin
        q_reg    <= bus.q;
        u        <= bus.a;
        v        <= bus.q;
        x1       <= ONE;
        x2       <= '0;
        err_pend <= bad_in;
        busy_reg <= 1'b1;
      end else if (do_step) begin
        u  <= u_step;
        v  <= v_step;
        x1 <= x1_step;
        x2 <= x2_step;
      end
      if (set_err) begin
        err_pend <= 1'b1;
      end
      if (state == FIN) begin
        done_reg <= 1'b1;
        busy_reg <= 1'b0;
        err_reg  <= err_pend;
        if (err_pend) begin
          out_reg <= '0;
        end else if (u == ONE) begin
          out_reg <= x1;
        end else begin
          out_reg <= x2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed bench for mod_inverse: known inverses, error cases, ignored restart, mid-run reset.
// Latency: checks done arrives within 4*WIDTH+2 cycles (exactly, with MODINV_CONST_TIME_EN).
// Backpressure: exercises start while busy and confirms it is dropped.
module tb_mod_inverse;
  localparam int WIDTH   = 28;
  localparam int LAT_MAX = 4 * WIDTH + 2;
  localparam logic [WIDTH-1:0] QP = 28'd268369921;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_inverse_if #(.WIDTH(WIDTH)) bus ();

  mod_inverse #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One full operation: pulse start, scramble inputs, wait for done, check pulse width and latency
  task automatic run_op(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] q_in,
                        output logic [WIDTH-1:0] o, output logic e);
    int lat;
    @(negedge clk);
    bus.a     = a_in;
    bus.q     = q_in;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = a_in + WIDTH'(1);
    bus.q     = q_in + WIDTH'(2);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    lat = 1;
    while (!bus.done && lat < LAT_MAX + 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      check("done_timeout", 64'(bus.done), 64'd1);
      o = '0;
      e = 1'b1;
    end else begin
      o = bus.out;
      e = bus.err;
      check("busy_low_at_done", 64'(bus.busy), 64'd0);
`ifdef MODINV_CONST_TIME_EN
      check("latency_exact", 64'(lat), 64'(LAT_MAX));
`else
      check("latency_bound", 64'(lat <= LAT_MAX), 64'd1);
`endif
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] o;
    logic             e;
    logic [WIDTH-1:0] ra;
    logic [63:0]      prod;
    int               ndone;
    logic [WIDTH-1:0] o5;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.q     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err",  64'(bus.err),  64'd0);
    check("rst_out",  64'(bus.out),  64'd0);
    rst = 1'b0;

    // Known inverses modulo q
    run_op(28'd1, QP, o, e);
    check("inv1_out", 64'(o), 64'd1);
    check("inv1_err", 64'(e), 64'd0);
    run_op(28'd2, QP, o, e);
    check("inv2_out", 64'(o), 64'd134184961);
    check("inv2_err", 64'(e), 64'd0);
    run_op(QP - 28'd1, QP, o, e);
    check("invqm1_out", 64'(o), 64'd268369920);
    run_op(28'd3, QP, o, e);
    check("inv3_out", 64'(o), 64'd178913281);

    // Operands outside [1, q-1]
    run_op(28'd0, QP, o, e);
    check("a0_err", 64'(e), 64'd1);
    check("a0_out", 64'(o), 64'd0);
    run_op(QP, QP, o, e);
    check("aq_err", 64'(e), 64'd1);
    check("aq_out", 64'(o), 64'd0);

    // Small composite modulus: gcd(6,15)=3 has no inverse, 7^-1 mod 15 = 13
    run_op(28'd6, 28'd15, o, e);
    check("gcd3_err", 64'(e), 64'd1);
    check("gcd3_out", 64'(o), 64'd0);
    run_op(28'd7, 28'd15, o, e);
    check("inv7_15_out", 64'(o), 64'd13);
    check("inv7_15_err", 64'(e), 64'd0);

    // Random operands, verified by multiplying back
    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom_range(1, 32'(QP) - 1));
      run_op(ra, QP, o, e);
      prod = ({36'd0, ra} * {36'd0, o}) % {36'd0, QP};
      check("rand_inv", prod, 64'd1);
      check("rand_err", 64'(e), 64'd0);
    end

    // Second start three cycles into an operation must be dropped
    @(negedge clk);
    bus.a     = 28'd5;
    bus.q     = QP;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    o5    = '0;
    for (int cyc = 1; cyc <= LAT_MAX + 20; cyc++) begin
      if (cyc == 3) begin
        bus.a     = 28'd7;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        o5 = bus.out;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("restart_done_count", 64'(ndone), 64'd1);
    check("restart_out", 64'(o5), 64'd214695937);

    // Reset in the middle of RUN aborts cleanly
    @(negedge clk);
    bus.a     = 28'd12345;
    bus.q     = QP;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_out",  64'(bus.out),  64'd0);
    rst = 1'b0;
    run_op(28'd3, QP, o, e);
    check("post_rst_out", 64'(o), 64'd178913281);
    check("post_rst_err", 64'(e), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
